// File: rtl/c7bicu_fetch_arb.sv
// c7bicu_fetch_arb: arbitrates the ICU ic1/ic2 fetch port between IFU demand fetch and the
// next-line prefetcher, tracks outstanding owners and squashes returns on exception.
`default_nettype none

module c7bicu_fetch_arb #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 64,
  parameter int MAX_OUT       = 2,
  parameter int PF_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifu_arb_req_ic1,
  input  logic [ADDR_W-1:0] ifu_arb_addr_ic1,
  output logic              arb_ifu_ack_ic1,
  output logic              arb_ifu_data_valid_ic2,
  input  logic              pf_arb_req,
  input  logic [ADDR_W-1:0] pf_arb_addr,
  output logic              arb_pf_ack,
  output logic              arb_pf_data_valid,
  output logic [DATA_W-1:0] arb_data_ic2,
  output logic              arb_icu_req_ic1,
  output logic [ADDR_W-1:0] arb_icu_addr_ic1,
  input  logic              icu_arb_ack_ic1,
  input  logic              icu_arb_data_valid_ic2,
  input  logic [DATA_W-1:0] icu_arb_data_ic2,
  input  logic              exu_ifu_except,
  output logic              arb_err
);

  localparam int CNT_W = (MAX_OUT < 2) ? 1 : $clog2(MAX_OUT + 1);
  localparam int STV_W = (PF_STARVE_MAX < 2) ? 1 : $clog2(PF_STARVE_MAX + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOCK_IFU = 2'd1;
  localparam logic [1:0] LOCK_PF  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [MAX_OUT-1:0] own_q, own_d;    // 1 = prefetcher owns the entry
  logic [MAX_OUT-1:0] kill_q, kill_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               err_q, err_d;

  logic             w_full;
  logic             w_sel_pf;
  logic             w_cand;
  logic             w_drop;
  logic             w_ack_ok;
  logic             w_pop;
  logic             w_deliver;
  logic [CNT_W-1:0] w_wr_idx;

  // Candidate request before exception gating; an ack against it is legal even
  // when the exception masks the request, and then lands as a killed entry.
  always_comb begin
    w_full   = (count_q == CNT_W'(MAX_OUT));
    w_sel_pf = 1'b0;
    w_cand   = 1'b0;
    w_drop   = 1'b0;
    case (state_q)
      IDLE: begin
        w_sel_pf = pf_arb_req && (!ifu_arb_req_ic1 || (starve_q == STV_W'(PF_STARVE_MAX)));
        w_cand   = (ifu_arb_req_ic1 || pf_arb_req) && !w_full;
      end
      LOCK_IFU: begin
        w_cand = ifu_arb_req_ic1 && !w_full;
        w_drop = !ifu_arb_req_ic1;
      end
      LOCK_PF: begin
        w_sel_pf = 1'b1;
        w_cand   = pf_arb_req && !w_full;
        w_drop   = !pf_arb_req;
      end
      default: begin
        w_cand = 1'b0;
      end
    endcase
    w_cand    = w_cand && resetn;
    w_ack_ok  = icu_arb_ack_ic1 && w_cand;
    w_pop     = icu_arb_data_valid_ic2 && (count_q != '0);
    w_deliver = w_pop && !kill_q[0] && !exu_ifu_except && resetn;
  end

  assign arb_icu_req_ic1        = w_cand && !exu_ifu_except;
  assign arb_icu_addr_ic1       = arb_icu_req_ic1 ? (w_sel_pf ? pf_arb_addr : ifu_arb_addr_ic1) : '0;
  assign arb_ifu_ack_ic1        = w_ack_ok && !w_sel_pf;
  assign arb_pf_ack             = w_ack_ok && w_sel_pf;
  assign arb_ifu_data_valid_ic2 = w_deliver && !own_q[0];
  assign arb_pf_data_valid      = w_deliver && own_q[0];
  assign arb_data_ic2           = icu_arb_data_ic2;
  assign arb_err                = err_q;

  always_comb begin
    state_d = state_q;
    if (exu_ifu_except) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (w_cand && !icu_arb_ack_ic1) state_d = w_sel_pf ? LOCK_PF : LOCK_IFU;
        LOCK_IFU,
        LOCK_PF:  if (w_drop || icu_arb_ack_ic1) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (exu_ifu_except) begin
      starve_d = '0;
    end else if ((state_q == IDLE) && w_cand) begin
      if (w_sel_pf) begin
        starve_d = '0;
      end else if (pf_arb_req && (starve_q != STV_W'(PF_STARVE_MAX))) begin
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  assign err_d = err_q
               || (icu_arb_data_valid_ic2 && (count_q == '0))
               || (icu_arb_ack_ic1 && !w_cand)
               || (w_drop && !exu_ifu_except);

  // Shift-register owner FIFO: slot 0 is the head, pushes land at the first free slot.
  always_comb begin
    own_d  = own_q;
    kill_d = kill_q | {MAX_OUT{exu_ifu_except}};
    if (w_pop) begin
      for (int i = 0; i < MAX_OUT - 1; i++) begin
        own_d[i]  = own_q[i+1];
        kill_d[i] = kill_q[i+1] | exu_ifu_except;
      end
      own_d[MAX_OUT-1]  = 1'b0;
      kill_d[MAX_OUT-1] = 1'b0;
    end
    w_wr_idx = count_q - CNT_W'(w_pop);
    for (int i = 0; i < MAX_OUT; i++) begin
      if (w_ack_ok && (CNT_W'(i) == w_wr_idx)) begin
        own_d[i]  = w_sel_pf;
        kill_d[i] = exu_ifu_except;
      end
    end
    count_d = count_q + CNT_W'(w_ack_ok) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      own_q    <= '0;
      kill_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      own_q    <= own_d;
      kill_q   <= kill_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_c7bicu_fetch_arb.sv
// Directed bench for c7bicu_fetch_arb with a return-data scoreboard.
`default_nettype none

module tb_c7bicu_fetch_arb;

  localparam logic [31:0] AI = 32'h0000_1000;
  localparam logic [31:0] AP = 32'h0000_2000;

  logic        clk;
  logic        resetn;
  logic        ifu_arb_req_ic1;
  logic [31:0] ifu_arb_addr_ic1;
  logic        arb_ifu_ack_ic1;
  logic        arb_ifu_data_valid_ic2;
  logic        pf_arb_req;
  logic [31:0] pf_arb_addr;
  logic        arb_pf_ack;
  logic        arb_pf_data_valid;
  logic [63:0] arb_data_ic2;
  logic        arb_icu_req_ic1;
  logic [31:0] arb_icu_addr_ic1;
  logic        icu_arb_ack_ic1;
  logic        icu_arb_data_valid_ic2;
  logic [63:0] icu_arb_data_ic2;
  logic        exu_ifu_except;
  logic        arb_err;

  typedef struct {
    logic [1:0]  own;   // 1 = IFU, 2 = PF
    logic [63:0] data;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "reset";

  c7bicu_fetch_arb dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .ifu_arb_req_ic1        (ifu_arb_req_ic1),
    .ifu_arb_addr_ic1       (ifu_arb_addr_ic1),
    .arb_ifu_ack_ic1        (arb_ifu_ack_ic1),
    .arb_ifu_data_valid_ic2 (arb_ifu_data_valid_ic2),
    .pf_arb_req             (pf_arb_req),
    .pf_arb_addr            (pf_arb_addr),
    .arb_pf_ack             (arb_pf_ack),
    .arb_pf_data_valid      (arb_pf_data_valid),
    .arb_data_ic2           (arb_data_ic2),
    .arb_icu_req_ic1        (arb_icu_req_ic1),
    .arb_icu_addr_ic1       (arb_icu_addr_ic1),
    .icu_arb_ack_ic1        (icu_arb_ack_ic1),
    .icu_arb_data_valid_ic2 (icu_arb_data_valid_ic2),
    .icu_arb_data_ic2       (icu_arb_data_ic2),
    .exu_ifu_except         (exu_ifu_except),
    .arb_err                (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs mid-cycle, then advance past the edge.
  task automatic step(input logic ir, input logic pr, input logic ak, input logic dv,
                      input logic [63:0] d, input logic ex,
                      input logic er, input logic [31:0] ea, input logic eia,
                      input logic epa, input logic [1:0] dlv);
    exp_t e;
    ifu_arb_req_ic1        = ir;
    ifu_arb_addr_ic1       = AI;
    pf_arb_req             = pr;
    pf_arb_addr            = AP;
    icu_arb_ack_ic1        = ak;
    icu_arb_data_valid_ic2 = dv;
    icu_arb_data_ic2       = d;
    exu_ifu_except         = ex;
    if (dlv != 2'd0) sb.push_back('{own: dlv, data: d});
    #2;
    chk("icu_req", 64'(arb_icu_req_ic1), 64'(er));
    chk("icu_addr", 64'(arb_icu_addr_ic1), 64'(ea));
    chk("ifu_ack", 64'(arb_ifu_ack_ic1), 64'(eia));
    chk("pf_ack", 64'(arb_pf_ack), 64'(epa));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ifu_dv", 64'(arb_ifu_data_valid_ic2), 64'(e.own == 2'd1));
      chk("pf_dv", 64'(arb_pf_data_valid), 64'(e.own == 2'd2));
      chk("data", arb_data_ic2, e.data);
    end else begin
      chk("ifu_dv_idle", 64'(arb_ifu_data_valid_ic2), 64'd0);
      chk("pf_dv_idle", 64'(arb_pf_data_valid), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] prev;
    logic       g;
    resetn = 1'b0;
    ifu_arb_req_ic1 = 1'b0; ifu_arb_addr_ic1 = AI; pf_arb_req = 1'b0; pf_arb_addr = AP;
    icu_arb_ack_ic1 = 1'b0; icu_arb_data_valid_ic2 = 1'b0; icu_arb_data_ic2 = '0;
    exu_ifu_except = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    step(1, 0, 0, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    chk("reset_err", 64'(arb_err), 64'd0);
    resetn = 1'b1;

    phase = "ifu_only";
    step(1, 0, 0, 0, 64'd0, 0,  1, AI, 0, 0, 2'd0);
    step(1, 0, 0, 0, 64'd0, 0,  1, AI, 0, 0, 2'd0);
    step(1, 0, 1, 0, 64'd0, 0,  1, AI, 1, 0, 2'd0);
    step(0, 0, 0, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    step(0, 0, 0, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    step(0, 0, 0, 1, 64'hDEADBEEF_00000010, 0,  0, 32'd0, 0, 0, 2'd1);
    chk("err", 64'(arb_err), 64'd0);

    phase = "pipeline";
    step(1, 0, 1, 0, 64'd0, 0,  1, AI, 1, 0, 2'd0);
    step(1, 0, 1, 0, 64'd0, 0,  1, AI, 1, 0, 2'd0);
    step(1, 0, 0, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    step(1, 0, 0, 1, 64'hA1, 0,  0, 32'd0, 0, 0, 2'd1);
    step(1, 0, 1, 1, 64'hA2, 0,  1, AI, 1, 0, 2'd1);
    step(0, 0, 0, 1, 64'hA3, 0,  0, 32'd0, 0, 0, 2'd1);
    chk("err", 64'(arb_err), 64'd0);

    phase = "starve";
    prev = 2'd0;
    for (int c = 0; c < 10; c++) begin
      g = ((c % 5) == 4);
      step(1, 1, 1, (c > 0), 64'hC0DE_0000 + 64'(c), 0,
           1, g ? AP : AI, !g, g, prev);
      prev = g ? 2'd2 : 2'd1;
    end
    step(0, 0, 0, 1, 64'hC0DE_0000 + 64'd10, 0,  0, 32'd0, 0, 0, prev);

    phase = "pf_lock";
    step(0, 1, 0, 0, 64'd0, 0,  1, AP, 0, 0, 2'd0);
    step(1, 1, 0, 0, 64'd0, 0,  1, AP, 0, 0, 2'd0);
    step(1, 1, 0, 0, 64'd0, 0,  1, AP, 0, 0, 2'd0);
    step(1, 1, 1, 0, 64'd0, 0,  1, AP, 0, 1, 2'd0);
    step(0, 0, 0, 1, 64'hBB, 0,  0, 32'd0, 0, 0, 2'd2);
    chk("err", 64'(arb_err), 64'd0);

    phase = "except";
    step(1, 0, 1, 0, 64'd0, 0,  1, AI, 1, 0, 2'd0);
    step(1, 0, 1, 0, 64'd0, 0,  1, AI, 1, 0, 2'd0);
    step(0, 0, 0, 0, 64'd0, 1,  0, 32'd0, 0, 0, 2'd0);
    step(0, 0, 0, 1, 64'hE1, 0,  0, 32'd0, 0, 0, 2'd0);
    step(0, 0, 0, 1, 64'hE2, 0,  0, 32'd0, 0, 0, 2'd0);
    step(1, 0, 1, 0, 64'd0, 0,  1, AI, 1, 0, 2'd0);
    step(0, 0, 0, 1, 64'hE3, 0,  0, 32'd0, 0, 0, 2'd1);
    chk("err", 64'(arb_err), 64'd0);

    phase = "ack_except";
    step(1, 0, 1, 0, 64'd0, 1,  0, 32'd0, 1, 0, 2'd0);
    step(0, 0, 0, 1, 64'hF1, 0,  0, 32'd0, 0, 0, 2'd0);
    chk("err", 64'(arb_err), 64'd0);

    phase = "dv_empty";
    step(0, 0, 0, 1, 64'hF2, 0,  0, 32'd0, 0, 0, 2'd0);
    chk("err_set", 64'(arb_err), 64'd1);
    step(0, 0, 0, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    chk("err_sticky", 64'(arb_err), 64'd1);

    phase = "reset_pulse";
    resetn = 1'b0;
    step(1, 1, 0, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    chk("err_cleared", 64'(arb_err), 64'd0);
    resetn = 1'b1;

    phase = "ack_no_req";
    step(0, 0, 1, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    chk("err_set", 64'(arb_err), 64'd1);
    resetn = 1'b0;
    step(0, 0, 0, 0, 64'd0, 0,  0, 32'd0, 0, 0, 2'd0);
    chk("err_cleared", 64'(arb_err), 64'd0);
    resetn = 1'b1;
    step(1, 0, 1, 0, 64'd0, 0,  1, AI, 1, 0, 2'd0);
    step(0, 0, 0, 1, 64'h77, 0,  0, 32'd0, 0, 0, 2'd1);
    chk("err_final", 64'(arb_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
